mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and write-back over multiple cycles.
- Drives the ALUopt code consumed by the ALU control unit, plus all mux, register-enable and memory strobes.
- Sits between the instruction register opcode field and the datapath; it is the only source of ALUopt.

Parameters:
- OPW, 6, opcode field width
- STW, 4, state register width (exported for debug)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- opcode  in  6  IR[31:26]; sampled only in DECODE
- zero  in  1  ALU zero flag; used for beq only
- mem_ready  in  1  memory handshake; used only when MEM_WAIT_EN is defined, otherwise ignored
- ALUopt  out  3  ALU control code: 000 add, 001 sub, 010 or, 011 and, 100 R-type (funct-decoded downstream)
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero; asserted in BRANCH
- pc_en  out  1  pc_write | (pc_write_cond & zero)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
- pc_source  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  STW  current state, debug

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101.
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.

Reset:
- rst_n=0 at a clk edge forces state=IDLE, regardless of the current state.
- All outputs are 0 in IDLE, with illegal_op=0.
- IDLE always moves to FETCH on the next edge.
- Reset asserted mid-instruction aborts it; no partial strobes follow.

Outputs are a pure function of the registered state, except pc_en, which also uses zero. Any signal not listed for a state is 0.
- FETCH: mem_read, ir_write, pc_write, alu_src_b=01, ALUopt=000, pc_source=00.
- DECODE: alu_src_b=11, ALUopt=000 (branch target into ALUOut).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUopt=000.
- MEM_RD: mem_read, i_or_d=1.
- MEM_WB: reg_write, mem_to_reg=1, reg_dst=0.
- MEM_WR: mem_write, i_or_d=1.
- R_EXEC: alu_src_a=1, alu_src_b=00, ALUopt=100.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUopt=001, pc_write_cond, pc_source=01.
- JUMP: pc_write, pc_source=10.
- I_EXEC: alu_src_a=1, alu_src_b=10; ALUopt=000 for addi, 011 for andi, 010 for ori. The immediate opcode is latched into an internal register in DECODE, so an opcode change during I_EXEC has no effect.
- I_WB: reg_write, reg_dst=0, mem_to_reg=0.

Transitions:
- FETCH→DECODE.
- DECODE branches on opcode:
  - lw/sw → MEM_ADDR
  - R → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi/andi/ori → I_EXEC
  - anything else → FETCH, with illegal_op=1 for exactly that transition cycle (registered, visible in the following cycle).
- MEM_ADDR → MEM_RD for lw, MEM_WR for sw (decided by the latched opcode).
- MEM_RD→MEM_WB; R_EXEC→R_WB; I_EXEC→I_WB.
- MEM_WB, MEM_WR, R_WB, I_WB, BRANCH and JUMP all → FETCH.

Latency in cycles, FETCH through last state: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3, illegal 2.

Optional Feature:
- Macro: MIPS_CTRL_MEM_WAIT_EN.
- Defined:
  - FETCH, MEM_RD and MEM_WR hold their state and keep their strobes asserted while mem_ready=0.
  - ir_write and pc_write in FETCH assert only in a cycle where mem_ready=1.
  - The FSM advances on the first cycle with mem_ready=1.
- Undefined: mem_ready is ignored; memory is single-cycle and the latencies above are exact.

Test Plan:
- rst_n=0 for 2 cycles, then 1 → state 0 with all outputs 0; FETCH (state 1) next cycle with mem_read=ir_write=pc_write=1, alu_src_b=01.
- opcode=000000 → state sequence 1,2,7,8,1; ALUopt=100 in state 7; reg_write=1 and reg_dst=1 in state 8.
- opcode=100011 → sequence 1,2,3,4,5,1; i_or_d=1 in 4; mem_to_reg=1 in 5. Repeat with opcode=101011 → 1,2,3,6,1 with mem_write=1 in 6.
- opcode=000100: zero=1 → pc_en=1 with ALUopt=001 in state 9; zero=0 → pc_en=0. opcode=001101 → ALUopt=010 in state 11.
- opcode=111111 → sequence 1,2,1 with one illegal_op pulse. Separately, rst_n=0 asserted while in state 4 → state 0 next edge, mem_read=0.
- With MIPS_CTRL_MEM_WAIT_EN defined: mem_ready=0 for 3 cycles in FETCH → state stays 1, ir_write=0; mem_ready=1 → ir_write=1 and state 2 next.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Signal bundle between the multi-cycle MIPS control FSM and its datapath.
// The master side is the controller; the slave side is the datapath.
interface mips_multicycle_ctrl_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic [2:0]     ALUopt;
  logic           pc_write;
  logic           pc_write_cond;
  logic           pc_en;
  logic           i_or_d;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     pc_source;
  logic           illegal_op;
  logic [STW-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output ALUopt, pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           pc_source, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ALUopt, pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multi-cycle MIPS datapath.
// Optional memory wait states: define MIPS_CTRL_MEM_WAIT_EN to stall FETCH,
// MEM_RD and MEM_WR until mem_ready is high; otherwise mem_ready is ignored.
module mips_multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [STW-1:0] {
    IDLE     = STW'(0),
    FETCH    = STW'(1),
    DECODE   = STW'(2),
    MEM_ADDR = STW'(3),
    MEM_RD   = STW'(4),
    MEM_WB   = STW'(5),
    MEM_WR   = STW'(6),
    R_EXEC   = STW'(7),
    R_WB     = STW'(8),
    BRANCH   = STW'(9),
    JUMP     = STW'(10),
    I_EXEC   = STW'(11),
    I_WB     = STW'(12)
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           illegal_d, illegal_q;
  logic           mem_go;

  logic [2:0] alu_op;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  // Single-cycle memory: the handshake is never consulted.
  logic mem_ready_unused;
  assign mem_ready_unused = bus.mem_ready;
  assign mem_go = 1'b1;
`endif

  // State, latched opcode and the illegal-opcode pulse, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == DECODE) op_q <= bus.opcode;
    end
  end

  // Next-state logic; opcode is only looked at in DECODE, later states use op_q.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = mem_go ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_R:                     state_d = R_EXEC;
          OP_BEQ:                   state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEM_ADDR: state_d = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem_go ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = mem_go ? FETCH : MEM_WR;
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_d = FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state; everything defaults low.
  always_comb begin
    alu_op        = 3'b000;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_go;
        pc_write  = mem_go;
        alu_src_b = 2'b01;
      end
      DECODE:   alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_ANDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b010;
          default: alu_op = 3'b000;
        endcase
      end
      I_WB:     reg_write = 1'b1;
      default:  ;
    endcase
  end

  assign bus.ALUopt        = alu_op;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_en         = pc_write | (pc_write_cond & bus.zero);
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl: walks every instruction class
// through its state sequence and compares state plus all control outputs.
module tb_mips_multicycle_ctrl;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_multicycle_ctrl_if #(.OPW(6), .STW(4)) bus ();

  mips_multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // All control outputs packed in one word for comparison.
  logic [18:0] outs;
  assign outs = {bus.ALUopt, bus.pc_write, bus.pc_write_cond, bus.pc_en,
                 bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                 bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                 bus.alu_src_b, bus.pc_source, bus.illegal_op};

  // Expected output word for a state, written from the control table.
  function automatic logic [18:0] exp_outs(input int st, input logic [2:0] iop,
                                           input logic z, input logic ill,
                                           input logic mr);
    logic [2:0] aop;
    logic pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, go;
    logic [1:0] sb, ps;
    aop = 3'b000; pw = 0; pwc = 0; iod = 0; mrd = 0; mwr = 0; irw = 0;
    rdst = 0; m2r = 0; rw = 0; sa = 0; sb = 2'b00; ps = 2'b00;
    go = mr | ~WAIT_EN;
    case (st)
      1:  begin mrd = 1; irw = go; pw = go; sb = 2'b01; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin mrd = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iod = 1; end
      7:  begin sa = 1; aop = 3'b100; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin sa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; end
      10: begin pw = 1; ps = 2'b10; end
      11: begin sa = 1; sb = 2'b10; aop = iop; end
      12: rw = 1;
      default: ;
    endcase
    return {aop, pw, pwc, pw | (pwc & z), iod, mrd, mwr, irw, rdst, m2r, rw,
            sa, sb, ps, ill};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int st,
                             input logic [2:0] iop, input logic ill);
    check_output({tag, " state"}, 32'(bus.state), 32'(st));
    check_output({tag, " outs"}, 32'(outs),
                 32'(exp_outs(st, iop, bus.zero, ill, bus.mem_ready)));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [5:0] op, input logic z);
    bus.opcode = op;
    bus.zero   = z;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cycle("reset idle", 0, 3'b000, 1'b0);

    // R-type: 1,2,7,8
    tick; check_cycle("R fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("R decode", 2, 3'b000, 1'b0);
    tick; check_cycle("R exec", 7, 3'b000, 1'b0);
    tick; check_cycle("R wb", 8, 3'b000, 1'b0);

    // lw: 1,2,3,4,5
    tick; apply_stimulus(OP_LW, 1'b0); check_cycle("lw fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("lw decode", 2, 3'b000, 1'b0);
    tick; check_cycle("lw addr", 3, 3'b000, 1'b0);
    tick; check_cycle("lw read", 4, 3'b000, 1'b0);
    tick; check_cycle("lw wb", 5, 3'b000, 1'b0);

    // sw: 1,2,3,6
    tick; apply_stimulus(OP_SW, 1'b0); check_cycle("sw fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("sw decode", 2, 3'b000, 1'b0);
    tick; check_cycle("sw addr", 3, 3'b000, 1'b0);
    tick; check_cycle("sw write", 6, 3'b000, 1'b0);

    // beq taken then not taken
    tick; apply_stimulus(OP_BEQ, 1'b1); check_cycle("beq1 fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("beq1 decode", 2, 3'b000, 1'b0);
    tick; check_cycle("beq1 branch", 9, 3'b000, 1'b0);
    check_output("beq1 pc_en", 32'(bus.pc_en), 32'd1);
    tick; apply_stimulus(OP_BEQ, 1'b0); check_cycle("beq0 fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("beq0 decode", 2, 3'b000, 1'b0);
    tick; check_cycle("beq0 branch", 9, 3'b000, 1'b0);
    check_output("beq0 pc_en", 32'(bus.pc_en), 32'd0);

    // ori, with opcode disturbed during I_EXEC to prove it was latched
    tick; apply_stimulus(OP_ORI, 1'b0); check_cycle("ori fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("ori decode", 2, 3'b000, 1'b0);
    tick; check_cycle("ori exec", 11, 3'b010, 1'b0);
    apply_stimulus(OP_ANDI, 1'b0);
    check_cycle("ori exec latched", 11, 3'b010, 1'b0);
    tick; check_cycle("ori wb", 12, 3'b000, 1'b0);

    // andi and addi ALU codes
    tick; check_cycle("andi fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("andi decode", 2, 3'b000, 1'b0);
    tick; check_cycle("andi exec", 11, 3'b011, 1'b0);
    tick; apply_stimulus(OP_ADDI, 1'b0); check_cycle("andi wb", 12, 3'b000, 1'b0);
    tick; check_cycle("addi fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("addi decode", 2, 3'b000, 1'b0);
    tick; check_cycle("addi exec", 11, 3'b000, 1'b0);
    tick; check_cycle("addi wb", 12, 3'b000, 1'b0);

    // Illegal opcode: 1,2,1 with a single illegal_op pulse
    tick; apply_stimulus(OP_BAD, 1'b0); check_cycle("bad fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("bad decode", 2, 3'b000, 1'b0);
    tick; apply_stimulus(OP_LW, 1'b0); check_cycle("bad refetch", 1, 3'b000, 1'b1);
    tick; check_cycle("bad pulse gone", 2, 3'b000, 1'b0);

    // Reset asserted while in MEM_RD aborts the load
    tick; check_cycle("abort addr", 3, 3'b000, 1'b0);
    tick; check_cycle("abort read", 4, 3'b000, 1'b0);
    rst_n = 1'b0;
    tick; check_cycle("abort idle", 0, 3'b000, 1'b0);
    check_output("abort mem_read", 32'(bus.mem_read), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(OP_J, 1'b0);

    // Jump: 1,2,10
    tick; check_cycle("j fetch", 1, 3'b000, 1'b0);
    tick; check_cycle("j decode", 2, 3'b000, 1'b0);
    tick; check_cycle("j jump", 10, 3'b000, 1'b0);
    tick; check_cycle("j refetch", 1, 3'b000, 1'b0);

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // FETCH stalls while memory is not ready
    apply_stimulus(OP_R, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_cycle("wait fetch", 1, 3'b000, 1'b0);
      check_output("wait ir_write", 32'(bus.ir_write), 32'd0);
      tick;
    end
    bus.mem_ready = 1'b1;
    #1;
    check_cycle("wait ready", 1, 3'b000, 1'b0);
    check_output("ready ir_write", 32'(bus.ir_write), 32'd1);
    tick; check_cycle("wait decode", 2, 3'b000, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
